// File: rtl/bus_command_pkg.sv
// Shared types for the 8288-style bus command controller: status codes,
// bus-cycle states and the wait-state counter width.
package bus_command_pkg;

  typedef enum logic [2:0] {
    ST_INTA       = 3'b000,
    ST_IO_READ    = 3'b001,
    ST_IO_WRITE   = 3'b010,
    ST_HALT       = 3'b011,
    ST_CODE_FETCH = 3'b100,
    ST_MEM_READ   = 3'b101,
    ST_MEM_WRITE  = 3'b110,
    ST_PASSIVE    = 3'b111
  } bus_status_t;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    TW,
    T4,
    HALT
  } bus_state_t;

  localparam int WAIT_COUNT_WIDTH = 3;

  // Cycle types where data flows from the bus into the CPU (DT/R low).
  function automatic logic is_receive(input bus_status_t s);
    return (s == ST_INTA) || (s == ST_IO_READ) ||
           (s == ST_CODE_FETCH) || (s == ST_MEM_READ);
  endfunction

endpackage

// File: rtl/bus_command_controller_if.sv
// CPU-side status/ready inputs and peripheral-side command strobes of the
// bus command controller; master = CPU/bench side, slave = controller.
interface bus_command_controller_if;
  logic [2:0] cpu_status;
  logic       ready;
  logic       address_enable_n;
  logic       address_latch_enable;
  logic       io_read_n;
  logic       io_write_n;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       interrupt_acknowledge_n;
  logic       data_transmit_receive_n;
  logic       data_enable;
  logic       bus_cycle_busy;

  modport master (
    output cpu_status, ready, address_enable_n,
    input  address_latch_enable, io_read_n, io_write_n, memory_read_n,
           memory_write_n, interrupt_acknowledge_n, data_transmit_receive_n,
           data_enable, bus_cycle_busy
  );

  modport slave (
    input  cpu_status, ready, address_enable_n,
    output address_latch_enable, io_read_n, io_write_n, memory_read_n,
           memory_write_n, interrupt_acknowledge_n, data_transmit_receive_n,
           data_enable, bus_cycle_busy
  );
endinterface

// File: rtl/bus_wait_counter.sv
// Wait-state down-counter: loads the forced TW count in T1 and counts down
// to zero; the zero flag gates the exit towards T4.
module bus_wait_counter
  import bus_command_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_load,
  input  logic [WAIT_COUNT_WIDTH-1:0] i_load_value,
  input  logic                        i_decrement,
  output logic                        o_count_zero
);

  logic [WAIT_COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_decrement && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count_zero = (r_count == '0);

endmodule

// File: rtl/bus_command_controller.sv
// 8288-style bus controller: decodes S2..S0 into registered command strobes,
// ALE, DT/R and DEN. Define BUS_CMD_ADVANCED_WRITE_EN for advanced-write timing.
module bus_command_controller
  import bus_command_pkg::*;
#(
  parameter int IO_WAIT_STATES  = 1,
  parameter int MEM_WAIT_STATES = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  bus_command_controller_if.slave  bus
);

  localparam logic [WAIT_COUNT_WIDTH-1:0] IO_WAIT_VALUE  = WAIT_COUNT_WIDTH'(IO_WAIT_STATES);
  localparam logic [WAIT_COUNT_WIDTH-1:0] MEM_WAIT_VALUE = WAIT_COUNT_WIDTH'(MEM_WAIT_STATES);

  bus_state_t  r_state, w_next_state;
  bus_status_t r_cycle_type, w_next_cycle_type;
  logic        r_passive_seen, w_next_passive_seen;

  bus_status_t w_status;
  logic        w_passive;
  logic        w_wait_zero;
  logic [WAIT_COUNT_WIDTH-1:0] w_load_value;

  logic r_ale, r_busy, r_den, r_dtr_n;
  logic r_ior_n, r_iow_n, r_mrd_n, r_mwr_n, r_inta_n;
  logic w_ale, w_busy, w_den, w_dtr_n;
  logic w_ior_n, w_iow_n, w_mrd_n, w_mwr_n, w_inta_n;
  logic w_in_cycle, w_read_phase, w_write_phase;

  assign w_status  = bus_status_t'(bus.cpu_status);
  assign w_passive = (w_status == ST_PASSIVE);

  always_comb begin
    w_load_value = MEM_WAIT_VALUE;
    case (r_cycle_type)
      ST_IO_READ, ST_IO_WRITE: w_load_value = IO_WAIT_VALUE;
      ST_INTA:                 w_load_value = '0;
      default:                 w_load_value = MEM_WAIT_VALUE;
    endcase
  end

  // Decrementing already in T3 makes N forced wait states yield exactly N TW clocks.
  bus_wait_counter u_wait_counter (
    .clock        (clock),
    .reset        (reset),
    .i_load       (r_state == T1),
    .i_load_value (w_load_value),
    .i_decrement  ((r_state == T3) || (r_state == TW)),
    .o_count_zero (w_wait_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cycle_type   <= ST_PASSIVE;
      r_passive_seen <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cycle_type   <= w_next_cycle_type;
      r_passive_seen <= w_next_passive_seen;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_cycle_type = r_cycle_type;
    case (r_state)
      IDLE, T4: begin
        if (r_passive_seen && !w_passive && (w_status != ST_HALT)) begin
          w_next_state      = T1;
          w_next_cycle_type = w_status;
        end else if (r_passive_seen && (w_status == ST_HALT)) begin
          w_next_state = HALT;
        end else begin
          w_next_state = IDLE;
        end
      end
      T1: w_next_state = T2;
      T2: w_next_state = T3;
      T3: w_next_state = (!w_wait_zero || !bus.ready) ? TW : T4;
      TW: if (w_wait_zero && bus.ready) w_next_state = T4;
      HALT: if (w_passive) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A passive status must be seen between cycles so stale status cannot retrigger.
  always_comb begin
    w_next_passive_seen = r_passive_seen;
    if (w_passive) begin
      w_next_passive_seen = 1'b1;
    end else if ((w_next_state == T1) || (w_next_state == HALT)) begin
      w_next_passive_seen = 1'b0;
    end
  end

  always_comb begin
    w_in_cycle    = (w_next_state == T1) || (w_next_state == T2) || (w_next_state == T3) ||
                    (w_next_state == TW) || (w_next_state == T4);
    w_read_phase  = (w_next_state == T2) || (w_next_state == T3) || (w_next_state == TW);
`ifdef BUS_CMD_ADVANCED_WRITE_EN
    w_write_phase = (w_next_state == T2) || (w_next_state == T3) || (w_next_state == TW);
`else
    w_write_phase = (w_next_state == T3) || (w_next_state == TW);
`endif
    w_ale    = (w_next_state == T1);
    w_busy   = w_in_cycle;
    w_den    = w_read_phase;
    w_dtr_n  = !(w_in_cycle && is_receive(w_next_cycle_type));
    w_ior_n  = 1'b1;
    w_iow_n  = 1'b1;
    w_mrd_n  = 1'b1;
    w_mwr_n  = 1'b1;
    w_inta_n = 1'b1;
    case (w_next_cycle_type)
      ST_INTA:                    w_inta_n = !w_read_phase;
      ST_IO_READ:                 w_ior_n  = !w_read_phase;
      ST_CODE_FETCH, ST_MEM_READ: w_mrd_n  = !w_read_phase;
      ST_IO_WRITE:                w_iow_n  = !w_write_phase;
      ST_MEM_WRITE:               w_mwr_n  = !w_write_phase;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ale    <= 1'b0;
      r_busy   <= 1'b0;
      r_den    <= 1'b0;
      r_dtr_n  <= 1'b1;
      r_ior_n  <= 1'b1;
      r_iow_n  <= 1'b1;
      r_mrd_n  <= 1'b1;
      r_mwr_n  <= 1'b1;
      r_inta_n <= 1'b1;
    end else begin
      r_ale    <= w_ale;
      r_busy   <= w_busy;
      r_den    <= w_den;
      r_dtr_n  <= w_dtr_n;
      r_ior_n  <= w_ior_n;
      r_iow_n  <= w_iow_n;
      r_mrd_n  <= w_mrd_n;
      r_mwr_n  <= w_mwr_n;
      r_inta_n <= w_inta_n;
    end
  end

  // DMA ownership blanks the strobes immediately; the FSM keeps sequencing.
  assign bus.address_latch_enable    = r_ale;
  assign bus.bus_cycle_busy          = r_busy;
  assign bus.data_enable             = r_den;
  assign bus.data_transmit_receive_n = r_dtr_n;
  assign bus.io_read_n               = r_ior_n  | bus.address_enable_n;
  assign bus.io_write_n              = r_iow_n  | bus.address_enable_n;
  assign bus.memory_read_n           = r_mrd_n  | bus.address_enable_n;
  assign bus.memory_write_n          = r_mwr_n  | bus.address_enable_n;
  assign bus.interrupt_acknowledge_n = r_inta_n | bus.address_enable_n;

endmodule
